// File: rtl/four_to_two_priority_encoder_if.sv
// ----------------------------------------------------------------------------
// four_to_two_priority_encoder_if
// Purpose : groups the input handshake, output handshake and status signals
//           of four_to_two_priority_encoder into one bundle.
// Signals :
//   d_n       [3:0]  active-low one-hot request code
//   in_valid         d_n is valid this cycle
//   in_ready         encoder can accept (buffer holds fewer than 2 entries)
//   y         [1:0]  encoded index of the head entry
//   err              head entry was not exactly one-low (optional checker)
//   out_valid        head entry present
//   out_ready        consumer accepts the head entry
//   xfer_cnt  [7:0]  number of completed output handshakes (wrapping)
// Modports: master = producer/consumer side, slave = encoder side.
// ----------------------------------------------------------------------------
interface four_to_two_priority_encoder_if;
   logic [3:0] d_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] y;
   logic       err;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] xfer_cnt;

   modport master (
      output d_n,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  y,
      input  err,
      input  out_valid,
      input  xfer_cnt
   );

   modport slave (
      input  d_n,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output y,
      output err,
      output out_valid,
      output xfer_cnt
   );
endinterface

// File: rtl/four_to_two_priority_encoder.sv
// ----------------------------------------------------------------------------
// four_to_two_priority_encoder
// Purpose : encodes an active-low 4-bit request code into a 2-bit index
//           (highest index wins) at accept time and queues the result in a
//           2-entry in-order buffer with valid/ready handshakes on both sides.
// Ports   :
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    four_to_two_priority_encoder_if.slave (see interface header)
// Config  : define FOUR_TO_TWO_ONEHOT_CHECK_EN to store an err flag with each
//           entry (set when the accepted d_n is not exactly one bit low).
//           Undefined: no err storage, err is tied to 0.
// ----------------------------------------------------------------------------
module four_to_two_priority_encoder (
   input  logic                                clk,
   input  logic                                rst_n,
   four_to_two_priority_encoder_if.slave       bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t     state_reg;
   logic [1:0] head_y_reg;
   logic [1:0] tail_y_reg;
   logic [7:0] xfer_cnt_reg;

   logic       accept;
   logic       transfer;
   logic [1:0] enc_y;

   // Scan upward so the highest low bit is the last one written and wins.
   // An all-ones code leaves the default of 00.
   always_comb begin
      enc_y = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (!bus.d_n[i]) begin
            enc_y = 2'(i);
         end
      end
   end

`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
   logic       head_err_reg;
   logic       tail_err_reg;
   logic [2:0] low_cnt;
   logic       enc_err;

   always_comb begin
      low_cnt = 3'd0;
      for (int i = 0; i < 4; i++) begin
         low_cnt = low_cnt + {2'b00, ~bus.d_n[i]};
      end
      enc_err = (low_cnt != 3'd1);
   end
`endif

   assign bus.in_ready  = (state_reg != TWO);
   assign bus.out_valid = (state_reg != EMPTY);
   assign accept        = bus.in_valid && bus.in_ready;
   assign transfer      = bus.out_valid && bus.out_ready;

   // Head register feeds y directly; it is cleared whenever the buffer
   // drains so that y reads 00 while out_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= EMPTY;
         head_y_reg   <= 2'b00;
         tail_y_reg   <= 2'b00;
         xfer_cnt_reg <= 8'd0;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
         head_err_reg <= 1'b0;
         tail_err_reg <= 1'b0;
`endif
      end else begin
         if (transfer) begin
            xfer_cnt_reg <= xfer_cnt_reg + 8'd1;
         end
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  state_reg  <= ONE;
                  head_y_reg <= enc_y;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
                  head_err_reg <= enc_err;
`endif
               end
            end
            ONE: begin
               if (accept && transfer) begin
                  // Head leaves while the new entry takes its place.
                  head_y_reg <= enc_y;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
                  head_err_reg <= enc_err;
`endif
               end else if (accept) begin
                  state_reg  <= TWO;
                  tail_y_reg <= enc_y;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
                  tail_err_reg <= enc_err;
`endif
               end else if (transfer) begin
                  state_reg  <= EMPTY;
                  head_y_reg <= 2'b00;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
                  head_err_reg <= 1'b0;
`endif
               end
            end
            TWO: begin
               // in_ready is low here, so only a transfer can change state.
               if (transfer) begin
                  state_reg  <= ONE;
                  head_y_reg <= tail_y_reg;
                  tail_y_reg <= 2'b00;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
                  head_err_reg <= tail_err_reg;
                  tail_err_reg <= 1'b0;
`endif
               end
            end
            default: begin
               state_reg <= EMPTY;
            end
         endcase
      end
   end

   assign bus.y        = head_y_reg;
   assign bus.xfer_cnt = xfer_cnt_reg;
`ifdef FOUR_TO_TWO_ONEHOT_CHECK_EN
   assign bus.err      = head_err_reg;
`else
   assign bus.err      = 1'b0;
`endif

endmodule

// File: doc/four_to_two_priority_encoder.md
FOUR_TO_TWO_PRIORITY_ENCODER -- requirements
Module: four_to_two_priority_encoder

Interface
REQ-001 The block SHALL have one clock, with an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 d_n  input  4  active-low one-hot code; d_n[i]=0 selects index i (i=0..3).
REQ-005 in_valid  input  1  d_n is valid this cycle.
REQ-006 in_ready  output  1  block can accept; high when buffer holds fewer than 2 entries.
REQ-007 y  output  2  encoded index {a,b} of the head entry.
REQ-008 err  output  1  head entry was not exactly one-low (only when ONEHOT_CHECK_EN is defined).
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 xfer_cnt  output  8  count of completed output handshakes.

Function
REQ-012 The block SHALL accept an input when in_valid && in_ready at a rising clk edge.
REQ-013 The block SHALL complete an output transfer when out_valid && out_ready at a rising clk edge.
REQ-014 Encoding SHALL use highest-priority-wins, highest index first:
- d_n[3]=0 -> y=11
- else d_n[2]=0 -> y=10
- else d_n[1]=0 -> y=01
- else d_n[0]=0 -> y=00
- all ones -> y=00
REQ-015 The block SHALL encode at accept time and store the result {y,err} in a 2-entry in-order buffer; d_n is not stored.
REQ-016 The buffer state machine SHALL have the states EMPTY, ONE and TWO. in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO. out_valid SHALL be 1 in ONE and TWO.
REQ-017 State transitions SHALL be:
- EMPTY + accept -> ONE
- ONE + accept without transfer -> TWO
- ONE + transfer without accept -> EMPTY
- ONE + accept and transfer in the same cycle -> ONE, with the new entry becoming head
- TWO + transfer -> ONE, with the second entry becoming head
- all other cases hold state
REQ-018 Latency SHALL be one cycle: an entry accepted at edge k appears on y/err with out_valid=1 after edge k, when the buffer was empty or the head transferred at edge k.
REQ-019 y and err SHALL be driven directly from the head register, with no combinational path from d_n to y.
REQ-020 y and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 When out_valid=0, y SHALL be 00 and err SHALL be 0.
REQ-022 xfer_cnt SHALL increment by 1 on each output transfer, wrap from 255 to 0, and not saturate.
REQ-023 in_valid while in TWO SHALL be ignored: there is no accept and no state change.

Reset
REQ-024 On rst_n=0, asynchronously and regardless of clk, the block SHALL set state to EMPTY, out_valid=0, y=00, err=0 and xfer_cnt=0; in_ready SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; no transfer SHALL occur in the cycle in which rst_n is released.

Configuration
REQ-026 The block SHALL use the macro FOUR_TO_TWO_ONEHOT_CHECK_EN.
- When defined: err=1 when the accepted d_n has zero or more than one bit low; y follows REQ-014.
- When undefined: the err register is removed and err is tied to 0; y is unchanged.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then d_n=1110/1101/1011/0111 each with in_valid=1 and out_ready=1 -> y=00/01/10/11 one cycle later; err=0; xfer_cnt=4.
- out_ready=0, push d_n=0111 then 1110 -> in_ready=0 after the 2nd push; a 3rd push is ignored; with out_ready=1, y=11 then 00.
- State ONE with in_valid=1 and out_ready=1 held for 10 cycles -> state stays ONE, one result per cycle, xfer_cnt=+10.
- With the macro defined: d_n=1111 -> y=00, err=1; d_n=0101 -> y=11, err=1. Without the macro, both give err=0.
- 256 transfers -> xfer_cnt returns to 0.
- rst_n pulsed low between edges while in TWO -> immediately out_valid=0, in_ready=1, xfer_cnt=0.
